// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM encoding and the default
// widths that match the CPU program ROM.
package program_loader_pkg;

  localparam int DEF_ADDR_WIDTH   = 5;
  localparam int DEF_OPCODE_WIDTH = 4;

  // state    | meaning
  // ST_IDLE  | no program, waiting for start
  // ST_LOAD  | accepting opcodes into program memory
  // ST_RUN   | program valid, CPU may execute
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

endpackage

// File: rtl/program_loader_if.sv
// Opcode load stream: valid/ready handshake with a last-opcode qualifier.
interface program_loader_if
  import program_loader_pkg::*;
#(
  parameter int OPCODE_WIDTH = DEF_OPCODE_WIDTH
) ();

  logic                    inValid;
  logic [OPCODE_WIDTH-1:0] inData;
  logic                    inLast;
  logic                    inReady;

  modport master (output inValid, output inData, output inLast, input  inReady);
  modport slave  (input  inValid, input  inData, input  inLast, output inReady);

endinterface

// File: rtl/program_ram.sv
// Program memory: synchronous write, combinational read. Contents are not
// reset so a program survives a loader reset until it is overwritten.
module program_ram
  import program_loader_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int OPCODE_WIDTH = DEF_OPCODE_WIDTH
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic [OPCODE_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0]   raddr,
  output logic [OPCODE_WIDTH-1:0] rdata
);

  logic [OPCODE_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/program_loader.sv
// Program loader: streams opcodes into program_ram, then releases the CPU.
// Optional macro PROGRAM_LOADER_CHECKSUM_EN enables the XOR checksum
// accumulator; without it the checksum port reads zero.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int OPCODE_WIDTH = DEF_OPCODE_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  program_loader_if.slave         ld,
  input  logic [ADDR_WIDTH-1:0]   addressIn,
  output logic [OPCODE_WIDTH-1:0] dataOut,
  output logic                    cpuRun,
  output logic [ADDR_WIDTH:0]     programLength,
  output logic [OPCODE_WIDTH-1:0] checksum
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   write_addr_q, write_addr_d;
  logic [ADDR_WIDTH:0]     prog_len_q, prog_len_d;
  logic                    in_ready_q, in_ready_d;
  logic                    cpu_run_q, cpu_run_d;
  logic                    xfer;
  logic [OPCODE_WIDTH-1:0] rd_data;

  assign xfer = (state_q == ST_LOAD) && in_ready_q && ld.inValid;

  // Next-state, address/length counters and registered handshake outputs
  always_comb begin
    state_d      = state_q;
    write_addr_d = write_addr_q;
    prog_len_d   = prog_len_q;
    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (start) begin
          state_d      = ST_LOAD;
          write_addr_d = '0;
          prog_len_d   = '0;
        end
      end
      ST_LOAD: begin
        if (xfer) begin
          write_addr_d = write_addr_q + 1'b1;
          prog_len_d   = prog_len_q + 1'b1;
          // A full memory ends the load even without inLast, so the
          // wrapped write address is never used.
          if (ld.inLast || (write_addr_q == LAST_ADDR)) state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d = (state_d == ST_LOAD);
    cpu_run_d  = (state_d == ST_RUN);
  end

  // FSM and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      write_addr_q <= '0;
      prog_len_q   <= '0;
      in_ready_q   <= 1'b0;
      cpu_run_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      write_addr_q <= write_addr_d;
      prog_len_q   <= prog_len_d;
      in_ready_q   <= in_ready_d;
      cpu_run_q    <= cpu_run_d;
    end
  end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [OPCODE_WIDTH-1:0] checksum_q, checksum_d;

  // Checksum cleared with the counters on a new load, folded per transfer
  always_comb begin
    checksum_d = checksum_q;
    if (start && (state_q != ST_LOAD)) checksum_d = '0;
    else if (xfer)                     checksum_d = checksum_q ^ ld.inData;
  end

  // Checksum register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) checksum_q <= '0;
    else        checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

  program_ram #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .OPCODE_WIDTH (OPCODE_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (xfer),
    .waddr (write_addr_q),
    .wdata (ld.inData),
    .raddr (addressIn),
    .rdata (rd_data)
  );

  assign ld.inReady    = in_ready_q;
  assign cpuRun        = cpu_run_q;
  assign programLength = prog_len_q;
  assign dataOut       = cpu_run_q ? rd_data : '0;

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, program memory address width (depth 2^ADDR_WIDTH).
REQ-002 Parameter OPCODE_WIDTH, default 4, width of one stored opcode.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port start  input  1  single-cycle load request.
REQ-006 Port inValid  input  1  opcode available on inData.
REQ-007 Port inData  input  OPCODE_WIDTH  opcode to store.
REQ-008 Port inLast  input  1  qualifies the final opcode of a program.
REQ-009 Port inReady  output  1  loader accepts an opcode this cycle.
REQ-010 Port addressIn  input  ADDR_WIDTH  CPU fetch address (program counter).
REQ-011 Port dataOut  output  OPCODE_WIDTH  opcode at addressIn.
REQ-012 Port cpuRun  output  1  program valid; CPU may execute.
REQ-013 Port programLength  output  ADDR_WIDTH+1  number of opcodes loaded.
REQ-014 Port checksum  output  OPCODE_WIDTH  XOR of loaded opcodes.

Function
REQ-015 The FSM SHALL have three states (IDLE, LOAD, RUN) and no others.
REQ-016 IDLE: inReady=0 and cpuRun=0; start=1 SHALL move the FSM to LOAD and clear writeAddr, programLength and checksum.
REQ-017 LOAD: inReady SHALL be 1; a transfer occurs only when inValid and inReady are both 1 on a clock edge.
REQ-018 Each transfer SHALL write inData to mem[writeAddr], increment writeAddr, and increment programLength.
REQ-019 A transfer with inLast=1 SHALL move the FSM to RUN on the same edge.
REQ-020 A transfer at writeAddr=2^ADDR_WIDTH-1 SHALL move the FSM to RUN regardless of inLast, with programLength=2^ADDR_WIDTH; writeAddr SHALL NOT wrap into further writes.
REQ-021 start asserted in LOAD SHALL be ignored.
REQ-022 RUN: cpuRun=1 and inReady=0.
REQ-023 start in RUN SHALL return the FSM to LOAD, with cpuRun=0 from the next cycle.
REQ-024 inValid outside LOAD SHALL be ignored, and memory SHALL NOT change.
REQ-025 dataOut SHALL equal mem[addressIn] combinationally while cpuRun=1, and SHALL be all-zero otherwise.
REQ-026 An opcode written on edge N SHALL be readable from edge N onward (zero-cycle read latency).
REQ-027 Addresses at or above programLength SHALL read stale memory contents; gating them is the CPU's job.

Reset
REQ-028 reset low SHALL immediately force the following values: state IDLE, writeAddr 0, programLength 0, checksum 0, inReady 0, cpuRun 0.
REQ-029 Memory contents SHALL NOT be reset.
REQ-030 Reset asserted mid-LOAD SHALL abandon the load; a new start is required.

Configuration
REQ-031 With macro PROGRAM_LOADER_CHECKSUM_EN defined, each transfer SHALL update checksum to checksum XOR inData.
REQ-032 Without PROGRAM_LOADER_CHECKSUM_EN, the checksum port SHALL still exist and SHALL be tied to zero, with no accumulator flops.

Structure
REQ-033 The following SHALL live in a shared package: the FSM state encoding, and default widths ADDR_WIDTH=5 and OPCODE_WIDTH=4 (matching the CPU program ROM).
REQ-034 The memory array with its combinational read and synchronous write SHALL be one sub-module, program_ram; the FSM, counters and checksum stay in program_loader.

Verification
REQ-035 Reset, then start, then 4 transfers of 0x1,0x2,0x3,0x4 with inLast on the 4th -> RUN, programLength=4, checksum=0x4 (macro on) or 0x0 (off), dataOut at address 2 = 0x3.
REQ-036 In LOAD with inValid toggling every other cycle over 3 transfers -> memory holds exactly the 3 opcodes at addresses 0-2, and no write occurs on cycles with inValid=0.
REQ-037 32 transfers with inLast=0 -> RUN after the 32nd, programLength=32; a 33rd inValid is ignored and address 0 is unchanged.
REQ-038 In RUN, start with inValid=1 and inData=0xF -> cpuRun=0 on the next cycle, LOAD with writeAddr=0, and 0xF written to address 0 only after inReady=1.
REQ-039 Assert reset after 2 of 5 transfers -> IDLE, cpuRun=0, dataOut=0; after a reload of 1 opcode, programLength=1.
REQ-040 Drive start while in LOAD -> writeAddr and programLength are not cleared.
